ap_hs_txn_sampler: RTL

// Synthesizable ap_ctrl_hs transaction sampler. It sits directly upstream of the dataflow

---
 rtl/ap_hs_txn_sampler_if.sv | 40 ++++
 rtl/ap_hs_txn_sampler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ap_hs_txn_sampler_if.sv
// Handshake bundle between an observed ap_ctrl_hs kernel, its record consumer and the sampler.
// The master side drives the kernel strobes and rec_ready; the slave side is the sampler.
interface ap_hs_txn_sampler_if #(
  parameter int CNT_W     = 32,
  parameter int TXN_W     = 16,
  parameter int MAX_OUTST = 4
);
  localparam int OW    = $clog2(MAX_OUTST + 1);
  localparam int REC_W = TXN_W + 2 * CNT_W;

  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             finish;
  // Record stream: a record transfers on a rising edge where rec_valid && rec_ready;
  // while rec_valid && !rec_ready, rec_data holds and rec_valid does not drop.
  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;
  logic [OW-1:0]    outstanding;
  logic [TXN_W-1:0] n_started;
  logic [TXN_W-1:0] n_done;
  logic             err_orphan;
  logic             err_overflow;
  logic             drained;
  logic [1:0]       fsm_state;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    input  rec_valid, rec_data, outstanding, n_started, n_done,
           err_orphan, err_overflow, drained, fsm_state
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    output rec_valid, rec_data, outstanding, n_started, n_done,
           err_orphan, err_overflow, drained, fsm_state
  );
endinterface

// File: rtl/ap_hs_txn_sampler.sv
// ap_ctrl_hs transaction sampler: pairs accepted starts with completions and streams
// {txn_id, start_ts, latency} records, with sticky protocol error flags and drain tracking.
module ap_hs_txn_sampler #(
  parameter int CNT_W     = 32,
  parameter int TXN_W     = 16,
  parameter int MAX_OUTST = 4,
  parameter int OUT_DEPTH = 8
) (
  input logic               ap_clk,
  input logic               ap_rst_n,
  ap_hs_txn_sampler_if.slave hs
);
  localparam int OW    = $clog2(MAX_OUTST + 1);
  localparam int SPW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OCW   = $clog2(OUT_DEPTH + 1);
  localparam int OPW   = $clog2(OUT_DEPTH);
  localparam int REC_W = TXN_W + 2 * CNT_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  logic             rst_meta_q, rst_sync_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] sf_mem_q [MAX_OUTST];
  logic [SPW-1:0]   sf_wr_q, sf_rd_q;
  logic [OW-1:0]    sf_cnt_q;
  logic [REC_W-1:0] of_mem_q [OUT_DEPTH];
  logic [OPW-1:0]   of_wr_q, of_rd_q;
  logic [OCW-1:0]   of_cnt_q;
  logic [TXN_W-1:0] n_started_q, n_done_q;
  logic             err_orphan_q, err_overflow_q, drained_q;
  state_e           state_q;

  logic             acc, cmp, sf_empty, sf_full, sf_push, sf_pop;
  logic             of_empty, of_full, of_push, of_pop;
  logic [CNT_W-1:0] ts;
  logic [REC_W-1:0] rec_new;

  function automatic logic [SPW-1:0] sp_next(input logic [SPW-1:0] p);
    return (p == SPW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign acc      = hs.ap_start & hs.ap_ready;
  assign cmp      = hs.ap_done & hs.ap_continue;
  assign sf_empty = (sf_cnt_q == '0);
  assign sf_full  = (sf_cnt_q == OW'(MAX_OUTST));
  assign of_empty = (of_cnt_q == '0);
  assign of_full  = (of_cnt_q == OCW'(OUT_DEPTH));
  // A completion only pairs with a start already queued before this edge.
  assign sf_pop   = cmp & ~sf_empty;
  assign sf_push  = acc & (~sf_full | sf_pop);
  assign of_pop   = ~of_empty & hs.rec_ready;
  assign of_push  = sf_pop & (~of_full | of_pop);
  assign ts       = sf_mem_q[sf_rd_q];
  assign rec_new  = {n_done_q, ts, cyc_q - ts};

  always_ff @(posedge ap_clk) begin
    if (sf_push) sf_mem_q[sf_wr_q] <= cyc_q;
    if (of_push) of_mem_q[of_wr_q] <= rec_new;
  end

  always_ff @(posedge ap_clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      cyc_q          <= '0;
      sf_wr_q        <= '0;
      sf_rd_q        <= '0;
      sf_cnt_q       <= '0;
      of_wr_q        <= '0;
      of_rd_q        <= '0;
      of_cnt_q       <= '0;
      n_started_q    <= '0;
      n_done_q       <= '0;
      err_orphan_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      cyc_q    <= cyc_q + 1'b1;
      sf_cnt_q <= sf_cnt_q + OW'(sf_push) - OW'(sf_pop);
      of_cnt_q <= of_cnt_q + OCW'(of_push) - OCW'(of_pop);
      if (sf_push) sf_wr_q <= sp_next(sf_wr_q);
      if (sf_pop)  sf_rd_q <= sp_next(sf_rd_q);
      if (of_push) of_wr_q <= of_wr_q + 1'b1;
      if (of_pop)  of_rd_q <= of_rd_q + 1'b1;
      if (acc)     n_started_q <= n_started_q + 1'b1;
      if (sf_pop)  n_done_q <= n_done_q + 1'b1;
      if (cmp & sf_empty) err_orphan_q <= 1'b1;
      if ((acc & ~sf_push) | (sf_pop & ~of_push)) err_overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q   <= S_IDLE;
      drained_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc) begin
            state_q <= S_RUN;
          end else if (hs.finish & sf_empty & of_empty) begin
            state_q   <= S_DONE;
            drained_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (hs.finish) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (sf_empty & of_empty) begin
            state_q   <= S_DONE;
            drained_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q   <= S_IDLE;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign hs.rec_valid    = ~of_empty;
  assign hs.rec_data     = of_empty ? '0 : of_mem_q[of_rd_q];
  assign hs.outstanding  = sf_cnt_q;
  assign hs.n_started    = n_started_q;
  assign hs.n_done       = n_done_q;
  assign hs.err_orphan   = err_orphan_q;
  assign hs.err_overflow = err_overflow_q;
  assign hs.drained      = drained_q;
  assign hs.fsm_state    = state_q;
endmodule
